// File: rtl/wb_regfile_scoreboard.sv
// Write-back stage: result select, 32-entry register file with write-through
// read ports, and a per-register pending-writer scoreboard for decode.
module wb_regfile_scoreboard #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ALUResultW,
  input  logic [WIDTH-1:0] ReadDataW,
  input  logic [WIDTH-1:0] PCPlus4W,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             ResultSrcW,
  input  logic             WD3SrcW,
  input  logic [4:0]       A1,
  input  logic [4:0]       A2,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  input  logic             IssueD,
  input  logic [4:0]       RdD,
  output logic             Busy1,
  output logic             Busy2,
  output logic             ScbErr,
  output logic [WIDTH-1:0] a0,
  output logic [31:0]      RetireCount
);

  logic [WIDTH-1:0] regs_q [32];
  logic [WIDTH-1:0] regs_d [32];
  logic [1:0]       pend_q [32];
  logic [1:0]       pend_d [32];
  logic             err_q, err_d;
  logic [WIDTH-1:0] a0_q, a0_d;
  logic [31:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0] result_w;
  logic             commit;
  logic             issue;
  logic             ret1, ret2;

  assign result_w = WD3SrcW ? PCPlus4W : (ResultSrcW ? ReadDataW : ALUResultW);
  assign commit   = RegWriteW && (RdW != 5'd0);
  assign issue    = IssueD && (RdD != 5'd0);

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    err_d  = err_q;
    a0_d   = a0_q;
    cnt_d  = cnt_q;
    if (commit) begin
      regs_d[RdW] = result_w;
      cnt_d       = cnt_q + 32'd1;
      if (RdW == 5'd10) a0_d = result_w;
    end
    // Issue and retire to the same register in one cycle cancel out.
    for (int r = 1; r < 32; r++) begin
      if (issue && (RdD == 5'(r)) && !(commit && (RdW == 5'(r)))) begin
        if (pend_q[r] == 2'd3) err_d = 1'b1;
        else                   pend_d[r] = pend_q[r] + 2'd1;
      end else if (commit && (RdW == 5'(r)) && !(issue && (RdD == 5'(r)))) begin
        if (pend_q[r] != 2'd0) pend_d[r] = pend_q[r] - 2'd1;
      end
    end
    regs_d[0] = '0;
    pend_d[0] = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= 2'd0;
      end
      err_q <= 1'b0;
      a0_q  <= '0;
      cnt_q <= 32'd0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      a0_q   <= a0_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ret1 = commit && (RdW == A1);
  assign ret2 = commit && (RdW == A2);

  assign RD1 = (A1 == 5'd0) ? '0 : (ret1 ? result_w : regs_q[A1]);
  assign RD2 = (A2 == 5'd0) ? '0 : (ret2 ? result_w : regs_q[A2]);

  // A retiring write counts as already gone; a zero count cannot go below zero.
  assign Busy1 = (A1 != 5'd0) && (ret1 ? (pend_q[A1] > 2'd1) : (pend_q[A1] != 2'd0));
  assign Busy2 = (A2 != 5'd0) && (ret2 ? (pend_q[A2] > 2'd1) : (pend_q[A2] != 2'd0));

  assign ScbErr      = err_q;
  assign a0          = a0_q;
  assign RetireCount = cnt_q;

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard: a vector table observed just
// before each rising edge, plus a fill-and-readback sequence over all registers.
module tb_wb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_w, rdata_w, pc_w;
  logic [4:0]  rd_w;
  logic        regwrite_w, resultsrc_w, wd3src_w;
  logic [4:0]  a1, a2;
  logic [31:0] rd1, rd2;
  logic        issue_d;
  logic [4:0]  rd_d;
  logic        busy1, busy2, scb_err;
  logic [31:0] a0, retire_count;

  int checks = 0;
  int errors = 0;

  wb_regfile_scoreboard #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResultW(alu_w), .ReadDataW(rdata_w), .PCPlus4W(pc_w),
    .RdW(rd_w), .RegWriteW(regwrite_w), .ResultSrcW(resultsrc_w), .WD3SrcW(wd3src_w),
    .A1(a1), .A2(a2), .RD1(rd1), .RD2(rd2),
    .IssueD(issue_d), .RdD(rd_d), .Busy1(busy1), .Busy2(busy2),
    .ScbErr(scb_err), .a0(a0), .RetireCount(retire_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        rw;
    logic [4:0]  rdw;
    logic        wd3;
    logic        rs;
    logic [31:0] alu;
    logic        iss;
    logic [4:0]  rdd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_b1;
    logic        e_b2;
    logic        e_err;
    logic [31:0] e_a0;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vt [64];
  int   nv;

  function automatic vec_t mk(
    input logic [31:0] rst, rw, rdw, wd3, rs, alu, iss, rdd, va1, va2,
    input logic [31:0] e_rd1, e_rd2, e_b1, e_b2, e_err, e_a0, e_cnt);
    vec_t v;
    v.rst_n = rst[0];   v.rw  = rw[0];    v.rdw = rdw[4:0];
    v.wd3   = wd3[0];   v.rs  = rs[0];    v.alu = alu;
    v.iss   = iss[0];   v.rdd = rdd[4:0];
    v.a1    = va1[4:0]; v.a2  = va2[4:0];
    v.e_rd1 = e_rd1;    v.e_rd2 = e_rd2;
    v.e_b1  = e_b1[0];  v.e_b2  = e_b2[0]; v.e_err = e_err[0];
    v.e_a0  = e_a0;     v.e_cnt = e_cnt;
    return v;
  endfunction

  // Driver tasks
  task automatic drive(input vec_t v);
    rst_n       = v.rst_n;
    regwrite_w  = v.rw;
    rd_w        = v.rdw;
    wd3src_w    = v.wd3;
    resultsrc_w = v.rs;
    alu_w       = v.alu;
    rdata_w     = 32'h22;
    pc_w        = 32'h33;
    issue_d     = v.iss;
    rd_d        = v.rdd;
    a1          = v.a1;
    a2          = v.a2;
  endtask

  task automatic idle();
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_q [$];

    // Fields: rst rw rdw wd3 rs alu iss rdd a1 a2 | rd1 rd2 b1 b2 err a0 cnt
    nv = 0;
    vt[nv++] = mk(1,0,0,0,0,0,              0,0,  5,31, 0,0,0,0,0,0,0);
    vt[nv++] = mk(1,1,3,0,0,'h11,           0,0,  3,0,  'h11,0,0,0,0,0,0);
    vt[nv++] = mk(1,0,0,0,0,0,              0,0,  3,0,  'h11,0,0,0,0,0,1);
    vt[nv++] = mk(1,1,3,0,1,'h11,           0,0,  3,0,  'h22,0,0,0,0,0,1);
    vt[nv++] = mk(1,0,0,0,0,0,              0,0,  3,0,  'h22,0,0,0,0,0,2);
    vt[nv++] = mk(1,1,3,1,1,'h11,           0,0,  3,0,  'h33,0,0,0,0,0,2);
    vt[nv++] = mk(1,0,0,0,0,0,              0,0,  3,0,  'h33,0,0,0,0,0,3);
    vt[nv++] = mk(1,1,7,0,0,'hDEADBEEF,     0,0,  7,3,  'hDEADBEEF,'h33,0,0,0,0,3);
    vt[nv++] = mk(1,1,0,0,0,5,              0,0,  0,7,  0,'hDEADBEEF,0,0,0,0,4);
    vt[nv++] = mk(1,0,0,0,0,0,              0,0,  0,7,  0,'hDEADBEEF,0,0,0,0,4);
    vt[nv++] = mk(1,0,0,0,0,0,              1,9,  9,0,  0,0,0,0,0,0,4);
    vt[nv++] = mk(1,0,0,0,0,0,              1,9,  9,0,  0,0,1,0,0,0,4);
    vt[nv++] = mk(1,1,9,0,0,'h91,           0,0,  9,0,  'h91,0,1,0,0,0,4);
    vt[nv++] = mk(1,1,9,0,0,'h92,           0,0,  9,0,  'h92,0,0,0,0,0,5);
    vt[nv++] = mk(1,0,0,0,0,0,              0,0,  9,0,  'h92,0,0,0,0,0,6);
    vt[nv++] = mk(1,0,0,0,0,0,              1,9,  9,0,  'h92,0,0,0,0,0,6);
    vt[nv++] = mk(1,1,9,0,0,'h93,           1,9,  9,9,  'h93,'h93,0,0,0,0,6);
    vt[nv++] = mk(1,0,0,0,0,0,              0,0,  9,0,  'h93,0,1,0,0,0,7);
    vt[nv++] = mk(1,1,9,0,0,'h94,           0,0,  9,0,  'h94,0,0,0,0,0,7);
    vt[nv++] = mk(1,0,0,0,0,0,              0,0,  9,0,  'h94,0,0,0,0,0,8);
    vt[nv++] = mk(1,0,0,0,0,0,              1,4,  0,4,  0,0,0,0,0,0,8);
    vt[nv++] = mk(1,0,0,0,0,0,              1,4,  0,4,  0,0,0,1,0,0,8);
    vt[nv++] = mk(1,0,0,0,0,0,              1,4,  0,4,  0,0,0,1,0,0,8);
    vt[nv++] = mk(1,0,0,0,0,0,              1,4,  0,4,  0,0,0,1,0,0,8);
    vt[nv++] = mk(1,0,0,0,0,0,              0,0,  0,4,  0,0,0,1,1,0,8);
    vt[nv++] = mk(1,1,12,0,0,'h12,          0,0,  12,4, 'h12,0,0,1,1,0,8);
    vt[nv++] = mk(1,0,0,0,0,0,              0,0,  12,4, 'h12,0,0,1,1,0,9);
    vt[nv++] = mk(1,1,10,0,0,'h2A,          0,0,  10,4, 'h2A,0,0,1,1,0,9);
    vt[nv++] = mk(1,0,0,0,0,0,              1,10, 10,4, 'h2A,0,0,1,1,'h2A,10);
    vt[nv++] = mk(0,1,10,0,0,'h99,          1,5,  10,4, 'h99,0,0,1,1,'h2A,10);
    vt[nv++] = mk(1,0,0,0,0,0,              0,0,  10,4, 0,0,0,0,0,0,0);
    vt[nv++] = mk(1,0,0,0,0,0,              0,0,  5,3,  0,0,0,0,0,0,0);
    vt[nv++] = mk(1,1,4,0,0,'h44,           0,0,  0,4,  0,'h44,0,0,0,0,0);
    vt[nv++] = mk(1,0,0,0,0,0,              0,0,  0,4,  0,'h44,0,0,0,0,1);

    // Reset: two cycles low before the table starts
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      check($sformatf("row%0d rd1", i),  rd1,             vt[i].e_rd1);
      check($sformatf("row%0d rd2", i),  rd2,             vt[i].e_rd2);
      check($sformatf("row%0d busy1", i), 32'(busy1),     32'(vt[i].e_b1));
      check($sformatf("row%0d busy2", i), 32'(busy2),     32'(vt[i].e_b2));
      check($sformatf("row%0d scberr", i), 32'(scb_err),  32'(vt[i].e_err));
      check($sformatf("row%0d a0", i),   a0,              vt[i].e_a0);
      check($sformatf("row%0d retire", i), retire_count,  vt[i].e_cnt);
    end

    // Fill x1..x31 with distinct values, then read every register back
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      drive(mk(1, 1, r, 0, 0, r * 32'h01010101, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(r * 32'h01010101);
    end
    @(negedge clk);
    idle();
    for (int r = 1; r < 32; r++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      @(negedge clk);
      a1 = 5'(r);
      a2 = 5'(32 - r);
      #1;
      check($sformatf("fill rd1 x%0d", r), rd1, e);
      check($sformatf("fill rd2 x%0d", 32 - r), rd2, (32 - r) * 32'h01010101);
    end
    a1 = 5'd0;
    #1;
    check("fill rd1 x0", rd1, 32'd0);
    check("fill retire", retire_count, 32'd32);
    check("fill a0", a0, 32'd10 * 32'h01010101);
    check("fill scberr", 32'(scb_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile_scoreboard.md
# wb_regfile_scoreboard

Write-back end of the MEM→WB pipeline register and decode-side register source. It selects the write-back result from the WB-stage data and control signals and commits it to a 32×WIDTH register file. It serves two decode read ports with same-cycle write-through bypass. A per-register pending-writer scoreboard flags decode operands whose producer has not yet retired.

## Interface
Parameters:
- WIDTH, 32, data/register width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- ALUResultW  in  WIDTH  ALU result from the MEM→WB register
- ReadDataW  in  WIDTH  load data from the MEM→WB register
- PCPlus4W  in  WIDTH  link value from the MEM→WB register
- RdW  in  5  destination register
- RegWriteW  in  1  write enable
- ResultSrcW  in  1  selects ReadDataW (1) or ALUResultW (0)
- WD3SrcW  in  1  selects PCPlus4W; overrides ResultSrcW
- A1, A2  in  5  decode read addresses
- RD1, RD2  out  WIDTH  decode read data (combinational)
- IssueD  in  1  an instruction writing RdD leaves decode this cycle
- RdD  in  5  destination of the issuing instruction
- Busy1, Busy2  out  1  operand A1/A2 has an un-retired writer (combinational)
- ScbErr  out  1  sticky scoreboard protocol error
- a0  out  WIDTH  registered copy of x10
- RetireCount  out  32  number of committed register writes

## Operation
- ResultW = WD3SrcW ? PCPlus4W : (ResultSrcW ? ReadDataW : ALUResultW).
- Commit condition is RegWriteW && RdW != 0. On commit, reg[RdW] <= ResultW at the posedge.
- x0 always reads 0. Writes to x0 are dropped and are not counted.
- Read port n: if An == 0, output 0. Else if the commit condition holds and RdW == An, output ResultW (bypass). Else output reg[An].
- Scoreboard: 2-bit counter pend[r] per register r=1..31. pend[0] is constant 0.
  - Issue event: IssueD && RdD != 0.
  - Retire event: the commit condition.
  - Issue only on r: pend[r] increments. If pend[r] == 3, it holds at 3 and sets ScbErr.
  - Retire only on r: pend[r] decrements. If pend[r] == 0, it stays 0 with no error, so testbench preload writes are legal.
  - Issue and retire on the same r in the same cycle: pend[r] is unchanged.
- Busyn = An != 0 && effective pend[An] > 0.
  - Effective pend is pend[An] - 1 when a retire to An occurs this cycle, else pend[An].
  - A same-cycle issue does not raise Busy until the next cycle.
- a0 tracks reg[10] and is updated on the same edge as an x10 commit.
- RetireCount increments by 1 per commit and wraps modulo 2^32.
- ScbErr is sticky until reset.

## Timing
- Write latency: one edge. Register contents change at the posedge where the commit condition is sampled.
- Read/bypass and Busy are combinational, with zero latency from A1/A2/RdW/RegWriteW.
- Reset, sampled at the posedge with rst_n = 0:
  - all reg[1..31], pend[*], a0, RetireCount and ScbErr become 0.
  - commits and issues presented in that same cycle are discarded.
- Reset mid-operation: in-flight pending counts are cleared. Retires arriving after reset decrement from 0, which saturates at 0.
- After reset, RD1/RD2 read 0 for all addresses unless a bypass is active.

## Test plan
- Reset then read: release rst_n, A1=5, A2=31 → RD1=RD2=0, Busy1=Busy2=0, a0=0, RetireCount=0.
- Result mux: RegWriteW=1, RdW=3, ALUResultW=0x11, ReadDataW=0x22, PCPlus4W=0x33 over three cycles with (WD3Src,ResultSrc)=(0,0),(0,1),(1,1) → reg[3] reads 0x11, 0x22, 0x33 in turn, and RetireCount=3.
- Bypass and x0: commit RdW=7, ResultW=0xDEADBEEF with A1=7 in the same cycle → RD1=0xDEADBEEF before the edge. Commit RdW=0 with 0x5 → RD of x0 = 0, and RetireCount unchanged.
- Scoreboard: issue RdD=9 → next cycle Busy1=1 for A1=9. Issue RdD=9 again → pend=2. Retire x9 twice → Busy1 drops to 0 combinationally during the second retire cycle. Same-cycle issue+retire on x9 → pend unchanged.
- Saturation/error: four issues of RdD=4 with no retire → pend=3 and ScbErr=1, sticky. A retire to x12 with pend 0 → no error, value written.
- a0 and mid-op reset: commit x10=0x2A → a0=0x2A next cycle. Assert rst_n=0 while a commit to x10=0x99 is presented → a0=0, reg[10]=0, and all Busy outputs are 0.
